// File: rtl/phase_sched_if.sv
// Request, engine and result signals shared between phase_sched and its neighbours.
// The slave modport is the scheduler's view; master is the front end / engine side.
interface phase_sched_if #(
  parameter int NCH = 4,
  parameter int CHW = 2
);
  logic [NCH-1:0]    req_valid;
  logic [NCH*13-1:0] req_x;
  logic [NCH*13-1:0] req_y;
  logic [NCH-1:0]    req_ready;
  logic              eng_start;
  logic [12:0]       eng_x;
  logic [12:0]       eng_y;
  logic [18:0]       eng_angle;
  logic              res_valid;
  logic [CHW-1:0]    res_ch;
  logic [18:0]       res_angle;
  logic              busy;

  modport slave (
    input  req_valid, req_x, req_y, eng_angle,
    output req_ready, eng_start, eng_x, eng_y, res_valid, res_ch, res_angle, busy
  );

  modport master (
    output req_valid, req_x, req_y, eng_angle,
    input  req_ready, eng_start, eng_x, eng_y, res_valid, res_ch, res_angle, busy
  );
endinterface

// File: rtl/phase_sched.sv
// Round-robin scheduler sharing one fixed-latency phase engine among NCH channels,
// returning each engine angle tagged with the channel that requested it.

module phase_sched_chk #(
  parameter int NCH = 4
) (
  input logic           clock,
  input logic           reset,
  input logic [NCH-1:0] req_valid,
  input logic [NCH-1:0] req_ready,
  input logic           eng_start,
  input logic           res_valid,
  input logic           busy
);
  a_grant_onehot:  assert property (@(posedge clock) disable iff (reset) $onehot0(req_ready));
  a_grant_valid:   assert property (@(posedge clock) disable iff (reset) (req_ready & ~req_valid) == '0);
  a_start_single:  assert property (@(posedge clock) disable iff (reset) eng_start |=> !eng_start);
  a_start_busy:    assert property (@(posedge clock) disable iff (reset) eng_start |-> busy);
  a_result_idle:   assert property (@(posedge clock) disable iff (reset) res_valid |-> !busy);
endmodule

module phase_sched #(
  parameter int NCH      = 4,
  parameter int CHW      = 2,
  parameter int CALC_LAT = 16
) (
  input logic          clock,
  input logic          reset,
  phase_sched_if.slave bus
);
  localparam int              SW       = 13;
  localparam int              CNTW     = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(CALC_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic            busy_r;
  logic [CHW-1:0]  rr_ptr_r;
  logic [CHW-1:0]  ch_r;
  logic [CNTW-1:0] cnt_r;
  logic            eng_start_r;
  logic [12:0]     eng_x_r;
  logic [12:0]     eng_y_r;
  logic            res_valid_r;
  logic [CHW-1:0]  res_ch_r;
  logic [18:0]     res_angle_r;

  logic [CHW-1:0]  idx_s;
  logic [CHW-1:0]  grant_ch_s;
  logic            grant_found_s;
  logic            grant_s;
  logic            issue_s;
  logic            done_s;
  logic [NCH-1:0]  req_ready_s;

  // Channel index base+k, wrapped modulo NCH (NCH need not be a power of two).
  function automatic logic [CHW-1:0] wrap_add(input logic [CHW-1:0] base, input int k);
    int sum;
    sum = int'(base) + k;
    return (sum >= NCH) ? CHW'(sum - NCH) : CHW'(sum);
  endfunction

  // Round-robin search: descending k so the closest requester to rr_ptr_r wins.
  always_comb begin
    grant_found_s = 1'b0;
    grant_ch_s    = '0;
    idx_s         = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx_s         = wrap_add(rr_ptr_r, k);
      grant_ch_s    = bus.req_valid[idx_s] ? idx_s : grant_ch_s;
      grant_found_s = grant_found_s | bus.req_valid[idx_s];
    end
  end

  // State register; busy is registered alongside the state it decodes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = grant_found_s ? ISSUE : IDLE;
      ISSUE:   state_s = WAIT;
      WAIT:    state_s = (cnt_r == '0) ? IDLE : WAIT;
      default: state_s = IDLE;
    endcase
  end

  // Per-state strobes and the combinational one-hot grant.
  always_comb begin
    grant_s     = 1'b0;
    issue_s     = 1'b0;
    done_s      = 1'b0;
    req_ready_s = '0;
    case (state_r)
      IDLE:    grant_s = grant_found_s & ~reset;
      ISSUE:   issue_s = 1'b1;
      WAIT:    done_s  = (cnt_r == '0);
      default: grant_s = 1'b0;
    endcase
    if (grant_s) begin
      req_ready_s = {{(NCH-1){1'b0}}, 1'b1} << grant_ch_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Datapath: operand capture, latency counter, result capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_r    <= '0;
      ch_r        <= '0;
      cnt_r       <= '0;
      eng_start_r <= 1'b0;
      eng_x_r     <= 13'd0;
      eng_y_r     <= 13'd0;
      res_valid_r <= 1'b0;
      res_ch_r    <= '0;
      res_angle_r <= 19'd0;
    end else begin
      eng_start_r <= grant_s;
      res_valid_r <= done_s;
      if (grant_s) begin
        eng_x_r  <= bus.req_x[int'(grant_ch_s)*SW +: SW];
        eng_y_r  <= bus.req_y[int'(grant_ch_s)*SW +: SW];
        ch_r     <= grant_ch_s;
        rr_ptr_r <= wrap_add(grant_ch_s, 1);
      end
      if (issue_s) begin
        cnt_r <= CNT_LOAD;
      end else if ((state_r == WAIT) && (cnt_r != '0)) begin
        cnt_r <= cnt_r - CNTW'(1'b1);
      end
      if (done_s) begin
        res_angle_r <= bus.eng_angle;
        res_ch_r    <= ch_r;
      end
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.eng_start = eng_start_r;
  assign bus.eng_x     = eng_x_r;
  assign bus.eng_y     = eng_y_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_ch    = res_ch_r;
  assign bus.res_angle = res_angle_r;
  assign bus.busy      = busy_r;

  phase_sched_chk #(.NCH(NCH)) u_chk (
    .clock     (clock),
    .reset     (reset),
    .req_valid (bus.req_valid),
    .req_ready (req_ready_s),
    .eng_start (eng_start_r),
    .res_valid (res_valid_r),
    .busy      (busy_r)
  );
endmodule

// File: tb/tb_phase_sched.sv
// Scoreboard bench for phase_sched: a rule-level grant model pushes expected results,
// an engine model answers eng_start, and a result monitor pops and compares.
module tb_phase_sched;
  localparam int NCH      = 4;
  localparam int CHW      = 2;
  localparam int CALC_LAT = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  phase_sched_if #(.NCH(NCH), .CHW(CHW)) bus ();

  phase_sched #(.NCH(NCH), .CHW(CHW), .CALC_LAT(CALC_LAT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int angle;
    int due;
  } exp_t;
  exp_t exp_q[$];

  int checks  = 0;
  int errors  = 0;
  int n_grant = 0;
  int n_start = 0;
  int n_res   = 0;
  int n_abort = 0;

  bit [NCH-1:0] pend = '0;
  int px[NCH];
  int py[NCH];

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int angle_of(int x, int y);
    real d;
    d = $atan2($itor(y), $itor(x)) * 180.0 / 3.14159265358979 * 1024.0;
    if (d >= 0.0) return $rtoi(d + 0.5);
    else return -$rtoi(0.5 - d);
  endfunction

  // Grant model: idle from free_at on, round-robin from m_ptr, result CALC_LAT+2 after grant.
  int free_at = 0;
  int start_due = -1;
  int m_ptr = 0;
  int m_grant = -1;
  always @(negedge clock) begin
    logic [NCH-1:0] exp_rdy;
    int i;
    exp_rdy = '0;
    m_grant = -1;
    if (!reset) begin
      chk("busy", bus.busy, (cyc < free_at));
      chk("eng_start", bus.eng_start, (cyc == start_due));
    end
    if (reset) begin
      free_at   = cyc + 1;
      start_due = -1;
      m_ptr     = 0;
    end else if (cyc >= free_at) begin
      for (int k = 0; k < NCH; k++) begin
        i = (m_ptr + k) % NCH;
        if (m_grant < 0 && bus.req_valid[i]) m_grant = i;
      end
      if (m_grant >= 0) begin
        exp_rdy[m_grant] = 1'b1;
        exp_q.push_back('{ch: m_grant,
                          angle: angle_of(int'($signed(bus.req_x[13*m_grant +: 13])),
                                          int'($signed(bus.req_y[13*m_grant +: 13]))),
                          due: cyc + CALC_LAT + 2});
        free_at   = cyc + CALC_LAT + 2;
        start_due = cyc + 1;
        m_ptr     = (m_grant + 1) % NCH;
        n_grant++;
      end
    end
    chk("req_ready", bus.req_ready, exp_rdy);
  end

  // Engine model: angle valid only in the cycle CALC_LAT after the start, noise otherwise.
  int eng_s = -1000;
  int eng_val = 0;
  int cap_x = 0;
  int cap_y = 0;
  always @(negedge clock) begin
    if (bus.eng_start) n_start++;
    if (bus.eng_start && !reset) begin
      eng_s   = cyc;
      cap_x   = int'($signed(bus.eng_x));
      cap_y   = int'($signed(bus.eng_y));
      eng_val = angle_of(cap_x, cap_y);
    end else if (!reset && cyc > eng_s && cyc <= eng_s + CALC_LAT + 1) begin
      chk("eng_x_hold", $signed(bus.eng_x), cap_x);
      chk("eng_y_hold", $signed(bus.eng_y), cap_y);
    end
    if (reset) eng_s = -1000;
  end

  always @(posedge clock) begin
    #1;
    bus.eng_angle = (cyc == eng_s + CALC_LAT) ? 19'(eng_val) : 19'($urandom);
  end

  // Result monitor: pops on res_valid, checks hold in between, flags missing results.
  int last_ch = 0;
  int last_angle = 0;
  always @(negedge clock) begin
    exp_t e;
    if (bus.res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL res_unexpected: got res_valid ch %0d with no outstanding grant (cycle %0d)",
                 bus.res_ch, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("res_ch", bus.res_ch, e.ch);
        chk("res_angle", $signed(bus.res_angle), e.angle);
        chk("res_cycle", cyc, e.due);
        last_ch    = e.ch;
        last_angle = e.angle;
        n_res++;
      end
    end else begin
      chk("res_ch_hold", bus.res_ch, last_ch);
      chk("res_angle_hold", $signed(bus.res_angle), last_angle);
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL res_timeout: got no res_valid by cycle %0d expected at cycle %0d", cyc, e.due);
      end
    end
    if (reset) begin
      n_abort += exp_q.size();
      exp_q.delete();
      last_ch    = 0;
      last_angle = 0;
    end
  end

  task automatic drive();
    for (int i = 0; i < NCH; i++) begin
      bus.req_valid[i]      = pend[i];
      bus.req_x[13*i +: 13] = 13'(px[i]);
      bus.req_y[13*i +: 13] = 13'(py[i]);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (m_grant >= 0) pend[m_grant] = 1'b0;
    drive();
  endtask

  task automatic set_req(input int ch, input int x, input int y);
    pend[ch] = 1'b1;
    px[ch]   = x;
    py[ch]   = y;
    drive();
  endtask

  task automatic wait_served(input string name);
    int n;
    n = 0;
    while (pend != '0 && n < 200) begin
      step();
      n++;
    end
    if (pend != '0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got pending 0x%0h expected all granted", name, pend);
      pend = '0;
      drive();
    end
  endtask

  task automatic serve(input string name, input int ch, input int x, input int y);
    set_req(ch, x, y);
    wait_served(name);
    repeat (CALC_LAT + 3) step();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NCH; i++) begin
      px[i] = 0;
      py[i] = 0;
    end
    drive();
    do_reset(3);

    // Single channel 2, 45 degrees.
    set_req(2, 100, 100);
    @(negedge clock);
    chk("t1_ready", bus.req_ready, 4'b0100);
    wait_served("t1");
    repeat (CALC_LAT + 3) step();
    chk("t1_angle", $signed(bus.res_angle), 46080);
    chk("t1_ch", bus.res_ch, 2);

    // All channels requesting continuously from reset.
    do_reset(2);
    for (int n = 0; n < 5 * (CALC_LAT + 2) + 2; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!pend[i]) begin
          pend[i] = 1'b1;
          px[i]   = int'($urandom_range(0, 8191)) - 4096;
          py[i]   = int'($urandom_range(0, 8191)) - 4096;
        end
      end
      drive();
      step();
    end
    pend = '0;
    drive();
    repeat (CALC_LAT + 3) step();

    // Pointer past ch1: ch0 must win over ch1.
    serve("t3a", 1, 300, -200);
    pend[0] = 1'b1; px[0] = -50;  py[0] = 70;
    pend[1] = 1'b1; px[1] = 1200; py[1] = 5;
    drive();
    @(negedge clock);
    chk("t3_ready", bus.req_ready, 4'b0001);
    wait_served("t3b");
    repeat (CALC_LAT + 3) step();

    // Reset during WAIT aborts the operation.
    set_req(0, 40, 90);
    wait_served("t4a");
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    chk("t4_busy", bus.busy, 0);
    serve("t4b", 3, -700, 333);

    // Sign and quadrant values pass through untouched.
    serve("t5a", 0, -100, 0);
    chk("t5_angle_180", $signed(bus.res_angle), 184320);
    serve("t5b", 0, -100, -1);
    chk("t5_angle_neg", $signed(bus.res_angle), -183733);

    // One-cycle pulse on ch1 while busy.
    set_req(0, 10, -10);
    wait_served("t6a");
    repeat (2) step();
    set_req(1, 77, 77);
    @(negedge clock);
    chk("t6_pulse_ready", bus.req_ready, 4'b0000);
    step();
    pend[1] = 1'b0;
    drive();
    repeat (CALC_LAT + 3) step();

    // Random requests with occasional withdrawals.
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 5) == 0) begin
            pend[i] = 1'b1;
            px[i]   = int'($urandom_range(0, 8191)) - 4096;
            py[i]   = int'($urandom_range(0, 8191)) - 4096;
          end
        end else if ($urandom_range(0, 40) == 0) begin
          pend[i] = 1'b0;
        end
      end
      drive();
      step();
    end
    pend = '0;
    drive();
    repeat (CALC_LAT + 5) step();

    chk("queue_empty", exp_q.size(), 0);
    chk("start_count", n_start, n_grant);
    chk("result_count", n_res + n_abort, n_grant);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
